put_controller_rr: RTL and testbench

Parametrised, registered successor to the single-requester put controller. It arbitrates `NUM_CH` producers onto one FIFO write port using round-robin priority. It gates writes against `full`/`almost_full` and returns a per-channel acknowledge. It also counts stalled cycles. It sits between the producer channels and the FIFO write side, driving the FIFO's `en_put` and write data.

---
 rtl/put_controller_rr.sv | 68 ++++++
 tb/tb_put_controller_rr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/put_controller_rr.sv
// put_controller_rr: round-robin arbiter of NUM_CH producers onto one registered FIFO write port with stall counting
module put_controller_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req_put,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     full,
    input  logic                     almost_full,
    input  logic                     stall_clr,
    output logic                     en_put,
    output logic [DATA_W-1:0]        data_out,
    output logic [NUM_CH-1:0]        ack_put,
    output logic [CNT_W-1:0]         stall_cnt
);
    localparam int PTR_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] eligible;
    logic              blocked;
    logic              grant_vld;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  idx;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_data[c] = data_in[c*DATA_W +: DATA_W];
    end

    // Pick the first eligible channel after rr_ptr; scanning farthest-first lets the nearest win
    always_comb begin
        eligible  = req_put & ~ack_put;
        blocked   = full | (almost_full & en_put);
        grant     = rr_ptr;
        idx       = rr_ptr;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_CH);
            if (eligible[idx]) grant = idx;
        end
        grant_vld = |eligible && !blocked;
    end

    // Register the write port and advance the priority pointer on each grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_put   <= 1'b0;
            ack_put  <= '0;
            data_out <= '0;
            rr_ptr   <= PTR_W'(NUM_CH - 1);
        end else begin
            en_put  <= grant_vld;
            ack_put <= grant_vld ? {{(NUM_CH-1){1'b0}}, 1'b1} << grant : '0;
            if (grant_vld) begin
                data_out <= ch_data[grant];
                rr_ptr   <= grant;
            end
        end
    end

    // Count cycles where someone wants to write but the FIFO cannot take it; clear wins
    always_ff @(posedge clk) begin
        if (!rst_n || stall_clr) stall_cnt <= '0;
        else if (|eligible && blocked && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_put_controller_rr.sv
// tb_put_controller_rr: scenario tasks with an expected-write scoreboard for put_controller_rr
module tb_put_controller_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_put;
    logic [31:0] data_in;
    logic        full;
    logic        almost_full;
    logic        stall_clr;
    logic        en_put;
    logic [7:0]  data_out;
    logic [3:0]  ack_put;
    logic [7:0]  stall_cnt;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    put_controller_rr #(.NUM_CH(4), .DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_put(req_put), .data_in(data_in),
        .full(full), .almost_full(almost_full), .stall_clr(stall_clr),
        .en_put(en_put), .data_out(data_out), .ack_put(ack_put), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_put = '0; full = 1'b0; almost_full = 1'b0; stall_clr = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_put = 4'hF; full = 1'b0; almost_full = 1'b0; stall_clr = 1'b0;
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++;
            if ({en_put, ack_put, data_out, stall_cnt} !== 21'd0)
                $display("FAIL reset_cyc%0d: en=%b ack=%b data=%h cnt=%0d, want all zero", c, en_put, ack_put, data_out, stall_cnt);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({en_put, ack_put, data_out} !== {1'b1, 4'b0001, 8'h10})
            $display("FAIL reset_first_grant: en=%b ack=%b data=%h, want 1 0001 10", en_put, ack_put, data_out);
        else pass_cnt++;
        req_put = '0;
    endtask

    task automatic test_single_channel();
        bit pat[6] = '{1, 0, 1, 0, 1, 0};
        do_reset();
        data_in = {8'h00, 8'h00, 8'hA5, 8'h00};
        req_put = 4'b0010;
        repeat (3) exp_q.push_back('{4'b0010, 8'hA5});
        for (int c = 0; c < 6; c++) begin
            tick();
            total_cnt++;
            if (en_put !== pat[c]) $display("FAIL single_en%0d: got %b want %b", c, en_put, pat[c]);
            else pass_cnt++;
            if (en_put === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL single_extra_write: ack=%b data=%h, want none", ack_put, data_out);
                else begin
                    e = exp_q.pop_front();
                    if (ack_put !== e.ack || data_out !== e.data)
                        $display("FAIL single_write%0d: ack=%b data=%h, want %b %h", c, ack_put, data_out, e.ack, e.data);
                    else pass_cnt++;
                end
            end
        end
        req_put = '0;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL single_missing: %0d writes left, want 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        req_put = 4'hF;
        foreach (order[k]) exp_q.push_back('{4'(1 << order[k]), 8'(8'h10 + order[k])});
        for (int c = 0; c < 6; c++) begin
            tick();
            total_cnt++;
            if (en_put !== 1'b1 || exp_q.size() == 0) $display("FAIL rr_en%0d: got %b want 1", c, en_put);
            else begin
                e = exp_q.pop_front();
                if (ack_put !== e.ack || data_out !== e.data)
                    $display("FAIL rr_write%0d: ack=%b data=%h, want %b %h", c, ack_put, data_out, e.ack, e.data);
                else pass_cnt++;
            end
        end
        req_put = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        req_put = 4'hF; full = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            total_cnt++;
            if (en_put !== 1'b0) $display("FAIL full_en%0d: got %b want 0", c, en_put);
            else pass_cnt++;
            if (c == 200 || c == 300) begin
                total_cnt++;
                if (stall_cnt !== 8'(c > 255 ? 255 : c)) $display("FAIL full_cnt%0d: got %0d want %0d", c, stall_cnt, c > 255 ? 255 : c);
                else pass_cnt++;
            end
        end
        stall_clr = 1'b1;
        tick();
        total_cnt++;
        if (stall_cnt !== 8'd0) $display("FAIL stall_clr: got %0d want 0", stall_cnt);
        else pass_cnt++;
        stall_clr = 1'b0;
        tick();
        total_cnt++;
        if (stall_cnt !== 8'd1) $display("FAIL stall_after_clr: got %0d want 1", stall_cnt);
        else pass_cnt++;
        full = 1'b0;
        tick();
        total_cnt++;
        if ({en_put, ack_put, data_out, stall_cnt} !== {1'b1, 4'b0001, 8'h10, 8'd1})
            $display("FAIL full_release: en=%b ack=%b data=%h cnt=%0d, want 1 0001 10 1", en_put, ack_put, data_out, stall_cnt);
        else pass_cnt++;
        req_put = '0;
    endtask

    task automatic test_almost_full();
        bit pat[4] = '{1, 0, 1, 0};
        bit prev = 1'b0;
        do_reset();
        data_in = {8'h00, 8'h00, 8'h21, 8'h20};
        req_put = 4'b0011; almost_full = 1'b1;
        exp_q.push_back('{4'b0001, 8'h20});
        exp_q.push_back('{4'b0010, 8'h21});
        for (int c = 0; c < 4; c++) begin
            tick();
            req_put = req_put & ~ack_put;
            total_cnt++;
            if (en_put !== pat[c] || (prev && en_put))
                $display("FAIL af_en%0d: got %b want %b (prev %b)", c, en_put, pat[c], prev);
            else pass_cnt++;
            prev = en_put;
            if (en_put === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) $display("FAIL af_extra_write: ack=%b data=%h, want none", ack_put, data_out);
                else begin
                    e = exp_q.pop_front();
                    if (ack_put !== e.ack || data_out !== e.data)
                        $display("FAIL af_write%0d: ack=%b data=%h, want %b %h", c, ack_put, data_out, e.ack, e.data);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (exp_q.size() != 0 || stall_cnt !== 8'd1)
            $display("FAIL af_end: left=%0d cnt=%0d, want 0 1", exp_q.size(), stall_cnt);
        else pass_cnt++;
        req_put = '0; almost_full = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        data_in = {8'h13, 8'h12, 8'h11, 8'h10};
        req_put = 4'hF;
        tick();
        total_cnt++;
        if (en_put !== 1'b1 || ack_put !== 4'b0001) $display("FAIL mid_pre: en=%b ack=%b, want 1 0001", en_put, ack_put);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        total_cnt++;
        if ({en_put, ack_put, data_out} !== 13'd0) $display("FAIL mid_reset: en=%b ack=%b data=%h, want 0 0000 00", en_put, ack_put, data_out);
        else pass_cnt++;
        rst_n = 1'b1;
        exp_q.push_back('{4'b0001, 8'h10});
        tick();
        total_cnt++;
        if (en_put !== 1'b1 || exp_q.size() == 0) $display("FAIL mid_restart_en: got %b want 1", en_put);
        else begin
            e = exp_q.pop_front();
            if (ack_put !== e.ack || data_out !== e.data)
                $display("FAIL mid_restart: ack=%b data=%h, want %b %h", ack_put, data_out, e.ack, e.data);
            else pass_cnt++;
        end
        req_put = '0;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_full_stall();
        test_almost_full();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
